// File: rtl/vol_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vol_ctrl
// Function : Debounced volume-up/down stepping with a saturating attenuation
//            level and a req/ack handshake carrying the decoder volume word.
//            Optional auto-repeat is enabled by defining VOL_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vol_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int          REPEAT_DELAY    = 50_000_000,
    parameter int          REPEAT_PERIOD   = 15_000_000,
    parameter int          MAX_LEVEL       = 8,
    parameter int          RESET_LEVEL     = 4,
    parameter logic [7:0]  ATTEN_STEP      = 8'd24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_dn,
    output logic [4:0]  vol_level,
    output logic [15:0] vol_word,
    output logic        vol_req,
    input  logic        vol_ack
);

    localparam int         DBW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [4:0] LVL_MAX   = 5'(MAX_LEVEL);
    localparam logic [4:0] LVL_RESET = 5'(RESET_LEVEL);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    function automatic logic [7:0] vol_byte(input logic [4:0] lv);
        if (lv == LVL_MAX)
            return 8'hFE;
        else
            return 8'({3'b000, lv} * ATTEN_STEP);
    endfunction

    // Index 0 = up button, index 1 = down button.
    logic [1:0] raw;
    logic [1:0] db;
    logic [1:0] press;
    logic [1:0] tick;

    assign raw = {btn_dn, btn_up};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [1:0]     sync;
        logic [DBW-1:0] cnt;
        logic           state;
        logic           state_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync    <= 2'b00;
                cnt     <= '0;
                state   <= 1'b0;
                state_q <= 1'b0;
            end else begin
                sync    <= {sync[0], raw[i]};
                state_q <= state;
                if (sync[1] == state) begin
                    cnt <= '0;
                end else if (cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    state <= ~state;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign db[i]    = state;
        assign press[i] = state & ~state_q;
    end

`ifdef VOL_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    for (genvar i = 0; i < 2; i++) begin : g_rep
        logic [RW-1:0] rcnt;
        logic          rphase;
        logic          excl;
        logic          hit;

        // rcnt equals the number of cycles since the press (or last repeat).
        assign excl = db[i] & ~db[1-i];
        assign hit  = rphase ? (rcnt == RW'(REPEAT_PERIOD)) : (rcnt == RW'(REPEAT_DELAY));

        always_ff @(posedge clk) begin
            if (rst || !excl) begin
                rcnt   <= '0;
                rphase <= 1'b0;
            end else if (hit) begin
                rcnt   <= RW'(1);
                rphase <= 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end

        assign tick[i] = excl & hit;
    end
`else
    // Repeat timing has no effect in this build; the expression is constant 0.
    assign tick = {2{(REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0)}};
`endif

    logic       both;
    logic       up_step;
    logic       dn_step;
    logic [4:0] level;
    logic [4:0] level_nxt;
    logic       chg;

    assign both    = db[0] & db[1];
    assign up_step = (press[0] | tick[0]) & ~both;
    assign dn_step = (press[1] | tick[1]) & ~both;

    always_comb begin
        level_nxt = level;
        chg       = 1'b0;
        if (up_step && level != 5'd0) begin
            level_nxt = level - 5'd1;
            chg       = 1'b1;
        end else if (dn_step && level != LVL_MAX) begin
            level_nxt = level + 5'd1;
            chg       = 1'b1;
        end
    end

    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic        pending;
    logic        pend_nxt;
    logic        load_word;
    logic [15:0] word;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_REQ;
        else
            state <= state_nxt;
    end

    // An ack that coincides with a fresh change is treated like a pending one,
    // so the change is never lost and vol_req stays high.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pending;
        load_word = 1'b0;
        case (state)
            ST_IDLE: begin
                if (chg) begin
                    state_nxt = ST_REQ;
                    load_word = 1'b1;
                end
            end
            ST_REQ: begin
                if (vol_ack) begin
                    if (pending || chg) begin
                        load_word = 1'b1;
                        pend_nxt  = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (chg) begin
                    pend_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    always_comb begin
        vol_req = (state == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= LVL_RESET;
            word    <= {2{vol_byte(LVL_RESET)}};
            pending <= 1'b0;
        end else begin
            level   <= level_nxt;
            pending <= pend_nxt;
            if (load_word)
                word <= {2{vol_byte(level_nxt)}};
        end
    end

    assign vol_level = level;
    assign vol_word  = word;

endmodule
`default_nettype wire

// File: tb/tb_vol_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vol_ctrl
// Function : Self-checking bench for vol_ctrl: directed scenarios plus random
//            button/ack/reset traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vol_ctrl;

    localparam int         DEB  = 4;
    localparam int         RD   = 20;
    localparam int         RP   = 8;
    localparam int         MAXL = 8;
    localparam int         RSTL = 4;
    localparam logic [7:0] AST  = 8'd24;

    logic        clk;
    logic        rst;
    logic        btn_up;
    logic        btn_dn;
    logic [4:0]  vol_level;
    logic [15:0] vol_word;
    logic        vol_req;
    logic        vol_ack;

    vol_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .MAX_LEVEL       (MAXL),
        .RESET_LEVEL     (RSTL),
        .ATTEN_STEP      (AST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_dn    (btn_dn),
        .vol_level (vol_level),
        .vol_word  (vol_word),
        .vol_req   (vol_req),
        .vol_ack   (vol_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input int lv);
        logic [7:0] b;
        if (lv == MAXL)
            b = 8'hFE;
        else
            b = 8'((lv * int'(AST)) % 256);
        return {b, b};
    endfunction

    // Behavioural model: state after the most recent rising edge.
    int          m_level;
    bit          m_req;
    bit          m_pend;
    logic [15:0] m_word;
    bit          m_s1 [2];
    bit          m_s2 [2];
    bit          m_db [2];
    bit          m_dbq[2];
    int          m_run[2];
    int          m_age[2];

    task automatic model_step(input bit up, input bit dn, input bit ack, input bit r);
        bit fire[2];
        bit chg;
        int nl;
        if (r) begin
            m_level = RSTL;
            m_word  = word_of(RSTL);
            m_req   = 1'b1;
            m_pend  = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_dbq[b] = 0;
                m_run[b] = 0; m_age[b] = 0;
            end
            return;
        end
        // Steps: on a fresh debounced press, and (auto-repeat) at age RD, RD+RP, ...
        for (int b = 0; b < 2; b++) begin
            fire[b] = 1'b0;
            if (m_db[b] && !m_db[1-b]) begin
                fire[b] = (m_age[b] == 0) && !m_dbq[b];
`ifdef VOL_AUTOREPEAT_EN
                if (m_age[b] >= RD && ((m_age[b] - RD) % RP) == 0)
                    fire[b] = 1'b1;
`endif
                m_age[b]++;
            end else begin
                m_age[b] = 0;
            end
        end
        nl  = m_level;
        chg = 1'b0;
        if (fire[0] && m_level > 0) begin
            nl = m_level - 1; chg = 1'b1;
        end else if (fire[1] && m_level < MAXL) begin
            nl = m_level + 1; chg = 1'b1;
        end
        if (m_req) begin
            if (ack) begin
                if (m_pend || chg) begin
                    m_word = word_of(nl);
                    m_pend = 1'b0;
                end else begin
                    m_req = 1'b0;
                end
            end else if (chg) begin
                m_pend = 1'b1;
            end
        end else if (chg) begin
            m_req  = 1'b1;
            m_word = word_of(nl);
        end
        m_level = nl;
        for (int b = 0; b < 2; b++) begin
            m_dbq[b] = m_db[b];
            if (m_s2[b] != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_db[b]  = ~m_db[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
            m_s2[b] = m_s1[b];
        end
        m_s1[0] = up;
        m_s1[1] = dn;
    endtask

    // One clock: drive inputs, advance the model, compare at the falling edge.
    task automatic cycle(input bit up, input bit dn, input bit ack, input bit r);
        btn_up  = up;
        btn_dn  = dn;
        vol_ack = ack;
        rst     = r;
        model_step(up, dn, ack, r);
        @(negedge clk);
        check("model_level", 32'(vol_level), 32'(m_level));
        check("model_word",  32'(vol_word),  32'(m_word));
        check("model_req",   32'(vol_req),   32'(m_req));
    endtask

    task automatic run(input bit up, input bit dn, input bit ack, input int n);
        for (int k = 0; k < n; k++)
            cycle(up, dn, ack, 1'b0);
    endtask

    initial begin
        int lv_base;
        int steps;
        int exp_lv;
        int rem [2];
        bit val [2];
        int cls;

        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("rst_level", 32'(vol_level), 32'd4);
        check("rst_word",  32'(vol_word),  32'h6060);
        check("rst_req",   32'(vol_req),   32'd1);
        cycle(0, 0, 1, 0);
        check("ack_drop", 32'(vol_req), 32'd0);

        run(0, 1, 0, 2);
        run(0, 0, 0, 12);
        check("bounce_level", 32'(vol_level), 32'd4);
        check("bounce_req",   32'(vol_req),   32'd0);

        for (int k = 1; k <= 10; k++) begin
            cycle(0, 1, 0, 0);
            if (k == 6) check("lat_before", 32'(vol_level), 32'd4);
            if (k == 7) begin
                check("lat_level", 32'(vol_level), 32'd5);
                check("lat_word",  32'(vol_word),  32'h7878);
                check("lat_req",   32'(vol_req),   32'd1);
            end
        end
        run(0, 0, 1, 12);

        for (int p = 0; p < 5; p++) begin
            run(0, 1, 0, 10);
            if (p >= 3) check("sat_no_req", 32'(vol_req), 32'd0);
            run(0, 0, 1, 10);
        end
        check("sat_level", 32'(vol_level), 32'd8);
        check("sat_word",  32'(vol_word),  32'hFEFE);

        for (int p = 0; p < 4; p++) begin
            run(1, 0, 0, 10);
            run(0, 0, 1, 10);
        end
        check("pre_hold_level", 32'(vol_level), 32'd4);

        for (int k = 1; k <= 60; k++) begin
            cycle(1, 0, 1, 0);
            steps = (k >= 7) ? 1 : 0;
`ifdef VOL_AUTOREPEAT_EN
            if (k >= 27) steps++;
            if (k >= 35) steps++;
            if (k >= 43) steps++;
            if (k >= 51) steps++;
`endif
            exp_lv = (4 - steps < 0) ? 0 : 4 - steps;
            check("hold_level", 32'(vol_level), 32'(exp_lv));
        end
        run(0, 0, 1, 15);

`ifdef VOL_AUTOREPEAT_EN
        lv_base = 0;
`else
        lv_base = 3;
`endif
        run(0, 1, 0, 10);
        check("pend_first", 32'(vol_word), 32'(word_of(lv_base + 1)));
        run(0, 0, 0, 10);
        run(0, 1, 0, 10);
        run(0, 0, 0, 5);
        check("pend_hold_word", 32'(vol_word), 32'(word_of(lv_base + 1)));
        check("pend_hold_req",  32'(vol_req),  32'd1);
        cycle(0, 0, 1, 0);
        check("pend_ack_req",  32'(vol_req),  32'd1);
        check("pend_ack_word", 32'(vol_word), 32'(word_of(lv_base + 2)));
        cycle(0, 0, 1, 0);
        check("pend_done_req", 32'(vol_req), 32'd0);

        for (int k = 0; k < 40; k++) begin
            cycle(1, 1, 0, 0);
            check("both_req", 32'(vol_req), 32'd0);
        end
        check("both_level", 32'(vol_level), 32'(lv_base + 2));
        run(0, 0, 0, 15);

        rem[0] = 0; rem[1] = 0; val[0] = 0; val[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (rem[b] == 0) begin
                    val[b] = 1'($urandom_range(0, 1));
                    cls    = int'($urandom_range(0, 3));
                    case (cls)
                        0:       rem[b] = int'($urandom_range(1, 3));
                        1:       rem[b] = int'($urandom_range(4, 12));
                        default: rem[b] = int'($urandom_range(20, 60));
                    endcase
                end
                rem[b]--;
            end
            cycle(val[0], val[1], ($urandom_range(0, 3) == 0), ($urandom_range(0, 499) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
